// File: rtl/alocador_vagas_pkg.sv
// Shared definitions for the parking-lot entry allocator: FSM states, lot geometry
// and the free-spot count helper used when PARKING_COUNT_EN is defined.
package alocador_vagas_pkg;

  localparam int unsigned N_VAGAS = 8;
  localparam int unsigned IDX_W   = 3;
  localparam logic [N_VAGAS-1:0] V_FULL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ALOCA,
    ABRE,
    ESPERA
  } estado_t;

  function automatic logic [3:0] livres_de(input logic [N_VAGAS-1:0] v);
    int unsigned ocup;
    ocup = 0;
    for (int unsigned i = 0; i < N_VAGAS; i++)
      if (v[i]) ocup++;
    return (ocup >= N_VAGAS) ? 4'd0 : 4'(N_VAGAS - ocup);
  endfunction

endpackage

// File: rtl/alocador_vagas_codificador_prioridade.sv
// Combinational lowest-set-bit encoder: idx is the lowest index with d[idx]=1,
// valid is low when no bit is set.
module codificador_prioridade
  import alocador_vagas_pkg::*;
(
  input  logic [N_VAGAS-1:0] d,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scanning downward lets the lowest set bit be the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = N_VAGAS; i > 0; i--) begin
      if (d[i-1]) begin
        idx   = IDX_W'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alocador_vagas.sv
// Entry-gate spot allocator: owns occupancy V, grants the lowest free spot, drives the
// barrier and processes exits every cycle. Optional LIVRES port under PARKING_COUNT_EN.
module alocador_vagas
  import alocador_vagas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ,
  input  logic               SAI,
  input  logic [IDX_W-1:0]   SAI_IDX,
  output logic               ACK,
  output logic               CHEIO,
  output logic [IDX_W-1:0]   GRANT_IDX,
  output logic               CANCELA,
  output logic [N_VAGAS-1:0] V,
  output logic               ERRO
`ifdef PARKING_COUNT_EN
  ,
  output logic [3:0]         LIVRES
`endif
);

  estado_t              estado;
  logic [3:0]           cnt;
  logic [IDX_W-1:0]     cod_idx;
  logic                 cod_valid;
  logic [N_VAGAS-1:0]   set_mask;
  logic [N_VAGAS-1:0]   clr_mask;
  logic                 saida_ilegal;
  logic [N_VAGAS-1:0]   v_next;

  codificador_prioridade u_codificador (
    .d     (~V),
    .idx   (cod_idx),
    .valid (cod_valid)
  );

  // Grant and exit masks both come from registered V, so an exit in the ALOCA
  // cycle never frees a spot for that same allocation.
  always_comb begin
    set_mask     = '0;
    clr_mask     = '0;
    saida_ilegal = 1'b0;
    if (estado == ALOCA && cod_valid)
      set_mask[cod_idx] = 1'b1;
    if (SAI) begin
      if (V[SAI_IDX]) clr_mask[SAI_IDX] = 1'b1;
      else            saida_ilegal      = 1'b1;
    end
    v_next = (V & ~clr_mask) | set_mask;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      estado    <= IDLE;
      cnt       <= '0;
      V         <= '0;
      ACK       <= 1'b0;
      CHEIO     <= 1'b0;
      GRANT_IDX <= '0;
      CANCELA   <= 1'b0;
      ERRO      <= 1'b0;
    end else begin
      V     <= v_next;
      ACK   <= 1'b0;
      CHEIO <= 1'b0;
      if (saida_ilegal) ERRO <= 1'b1;
      unique case (estado)
        IDLE: if (REQ) estado <= ALOCA;
        ALOCA: begin
          ACK <= 1'b1;
          if (V != V_FULL) begin
            GRANT_IDX <= cod_idx;
            CANCELA   <= 1'b1;
            cnt       <= 4'(GATE_CYCLES);
            estado    <= ABRE;
          end else begin
            CHEIO  <= 1'b1;
            estado <= ESPERA;
          end
        end
        // The load value already counts the ACK cycle, so the barrier closes
        // on the edge where the counter reads 1.
        ABRE: begin
          if (cnt <= 4'd1) begin
            CANCELA <= 1'b0;
            estado  <= ESPERA;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ESPERA: if (!REQ) estado <= IDLE;
      endcase
    end
  end

`ifdef PARKING_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RST) LIVRES <= 4'd8;
    else     LIVRES <= livres_de(v_next);
  end
`endif

endmodule

// File: tb/tb_alocador_vagas.sv
// Scoreboard bench for alocador_vagas: a lot-level reference model predicts each grant,
// a monitor checks ACK responses and per-cycle V/ERRO/CANCELA(/LIVRES).
module tb_alocador_vagas;

  localparam int unsigned G = 4;

  logic       CLK = 1'b0;
  logic       RST, REQ, SAI;
  logic [2:0] SAI_IDX;
  logic       ACK, CHEIO, CANCELA, ERRO;
  logic [2:0] GRANT_IDX;
  logic [7:0] V;
`ifdef PARKING_COUNT_EN
  logic [3:0] LIVRES;
`endif

  alocador_vagas #(.GATE_CYCLES(G)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .SAI       (SAI),
    .SAI_IDX   (SAI_IDX),
    .ACK       (ACK),
    .CHEIO     (CHEIO),
    .GRANT_IDX (GRANT_IDX),
    .CANCELA   (CANCELA),
    .V         (V),
    .ERRO      (ERRO)
`ifdef PARKING_COUNT_EN
    ,
    .LIVRES    (LIVRES)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         cheio;
    logic [2:0] idx;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];

  // Reference model of the lot: occupancy, sticky error, last granted spot,
  // remaining barrier-open cycles.
  logic [7:0] mv;
  bit         merr;
  logic [2:0] mlast;
  int         mcl;
  bit         mon_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge; grant marks the edge that ends the allocation cycle.
  task automatic step(input bit grant);
    logic [7:0] nv;
    bit         ne;
    int         ncl;
    int         k;
    exp_t       e;
    if (RST) begin
      nv = '0; ne = 1'b0; ncl = 0; mlast = '0;
    end else begin
      nv  = mv;
      ne  = merr;
      ncl = (mcl > 0) ? mcl - 1 : 0;
      k   = -1;
      if (grant) begin
        for (int i = 0; i < 8; i++)
          if (k < 0 && !mv[i]) k = i;
        if (k >= 0) begin
          nv[k] = 1'b1;
          mlast = 3'(k);
          ncl   = G;
        end
      end
      if (SAI) begin
        if (mv[SAI_IDX]) nv[SAI_IDX] = 1'b0;
        else             ne = 1'b1;
      end
      if (grant) begin
        e.cheio = (k < 0);
        e.idx   = mlast;
        e.v     = nv;
        q.push_back(e);
      end
    end
    @(posedge CLK);
    mv = nv; merr = ne; mcl = ncl;
    #1;
  endtask

  task automatic set_exit(input int pct);
    int s;
    SAI = 1'b0;
    if (int'($urandom_range(99)) < pct) begin
      SAI = 1'b1;
      s = int'($urandom_range(7));
      SAI_IDX = 3'(s);
      if ($urandom_range(3) != 0)
        for (int i = 0; i < 8; i++)
          if (mv[(s + i) % 8]) begin
            SAI_IDX = 3'((s + i) % 8);
            break;
          end
    end
  endtask

  task automatic exit_once(input int idx);
    SAI = 1'b1; SAI_IDX = 3'(idx);
    step(1'b0);
    SAI = 1'b0;
  endtask

  task automatic txn(input int pre, input int hold, input int pct, input int alo_exit);
    for (int i = 0; i < pre; i++) begin set_exit(pct); step(1'b0); end
    REQ = 1'b1; set_exit(pct); step(1'b0);
    if (alo_exit >= 0) begin SAI = 1'b1; SAI_IDX = 3'(alo_exit); end
    else set_exit(pct);
    step(1'b1);
    for (int i = 0; i < hold; i++) begin set_exit(pct); step(1'b0); end
    REQ = 1'b0;
    for (int i = 0; i < int'(G) + 2; i++) begin set_exit(pct); step(1'b0); end
    SAI = 1'b0;
    chk("ack_received", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = 1'b0; SAI = 1'b0;
    step(1'b0); step(1'b0);
    RST = 1'b0;
  endtask

  task automatic reset_in_abre();
    REQ = 1'b1; step(1'b0);
    step(1'b1);
    step(1'b0);
    RST = 1'b1; REQ = 1'b0;
    step(1'b0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("ack_before_reset", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  // Monitor: per-cycle state checks plus scoreboard pop on every ACK.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        chk("v", 32'(V), 32'(mv));
        chk("erro", 32'(ERRO), 32'(merr));
        chk("cancela", 32'(CANCELA), 32'(mcl > 0));
`ifdef PARKING_COUNT_EN
        chk("livres", 32'(LIVRES), 32'(8 - $countones(mv)));
`endif
        if (ACK) begin
          if (q.size() == 0) begin
            chk("unexpected_ack", 32'(ACK), 32'd0);
          end else begin
            e = q.pop_front();
            chk("cheio", 32'(CHEIO), 32'(e.cheio));
            chk("grant_idx", 32'(GRANT_IDX), 32'(e.idx));
            chk("v_at_ack", 32'(V), 32'(e.v));
          end
        end
      end
    end
  end

  initial begin
    RST = 1'b1; REQ = 1'b0; SAI = 1'b0; SAI_IDX = '0;
    mv = '0; merr = 1'b0; mlast = '0; mcl = 0;
    do_reset();
    mon_en = 1'b1;
    @(negedge CLK);
    chk("rst_ack", 32'(ACK), 32'd0);
    chk("rst_cheio", 32'(CHEIO), 32'd0);
    chk("rst_grant_idx", 32'(GRANT_IDX), 32'd0);

    // Fill from empty, with a mid-fill exit to reach 8'h0B.
    txn(0, G + 2, 0, -1);
    for (int i = 0; i < 3; i++) txn(1, 1, 0, -1);
    exit_once(2);
    txn(0, 0, 0, -1);
    for (int i = 0; i < 4; i++) txn(0, 2, 0, -1);
    txn(0, 3, 0, -1);
    // Exit during the allocation cycle of a full lot is not seen by that request.
    txn(0, 1, 0, 5);
    txn(0, 1, 0, -1);
    exit_once(3);
    exit_once(3);
    txn(0, 1, 0, -1);
    txn(0, 1, 0, -1);

    do_reset();
    reset_in_abre();
    txn(0, 0, 0, -1);

    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int i = 0; i < 40; i++)
        txn(int'($urandom_range(0, 3)), int'($urandom_range(0, G + 3)),
            (blk % 2 == 1) ? 25 : 4,
            ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1);
      reset_in_abre();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
